// File: rtl/gpio_port_bank.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_port_bank
//  Description : SFR port-register bank with output latches, input
//                synchronisers, alternate-function override and maskable
//                falling-edge interrupt capture.
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_port_bank #(
    parameter int         NPORTS      = 4,
    parameter int         PW          = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] BASE_ADDR   = 7'h00,
    parameter logic [6:0] STRIDE      = 7'h10,
    parameter logic [7:0] RST_VAL     = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS*PW-1:0] port_i,
    output logic [NPORTS*PW-1:0] port_o,
    input  logic [NPORTS*PW-1:0] alt_en,
    input  logic [NPORTS*PW-1:0] alt_o,
    input  logic                 rmwinstr,
    input  logic [6:0]           sfraddr,
    input  logic [7:0]           sfrdatai,
    input  logic                 sfrwe,
    output logic [7:0]           sfrdata_o,
    output logic                 sfrsel_o,
    output logic                 irq_o
);

    localparam int         c_BUS_W   = NPORTS * PW;
    localparam logic [2:0] c_ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][c_BUS_W-1:0] r_sync;
    logic [c_BUS_W-1:0]                  r_prev;
    logic [c_BUS_W-1:0]                  w_s;
    logic [c_BUS_W-1:0]                  w_edge;
    logic [2:0]                          r_arm_cnt;
    logic                                w_armed;
    logic                                r_irq;
    logic                                w_irq_any;

    logic [PW-1:0] w_pl   [NPORTS];
    logic [PW-1:0] w_rd   [NPORTS];
    logic          w_sel  [NPORTS];
    logic          w_pend [NPORTS];

    // Synchroniser chain; r_prev holds last cycle's synchronised sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= {NPORTS{RST_VAL}};
            end
            r_prev <= {NPORTS{RST_VAL}};
        end else begin
            r_sync[0] <= port_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_prev <= w_s;
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_edge = r_prev & ~w_s;

    // Edges are ignored until the synchroniser has flushed its reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arm_cnt <= 3'd0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + 3'd1;
        end
    end

    assign w_armed = (r_arm_cnt == c_ARM_MAX);

    generate
        for (genvar i = 0; i < NPORTS; i++) begin : g_port
            localparam logic [6:0] c_ADDR_PL = 7'(BASE_ADDR + i * STRIDE);
            localparam logic [6:0] c_ADDR_EF = 7'(BASE_ADDR + i * STRIDE + 1);
            localparam logic [6:0] c_ADDR_EM = 7'(BASE_ADDR + i * STRIDE + 2);

            logic [PW-1:0] r_pl;
            logic [PW-1:0] r_ef;
            logic [PW-1:0] r_em;
            logic          w_hit_pl;
            logic          w_hit_ef;
            logic          w_hit_em;
            logic [PW-1:0] w_ef_kept;

            assign w_hit_pl = (sfraddr == c_ADDR_PL);
            assign w_hit_ef = (sfraddr == c_ADDR_EF);
            assign w_hit_em = (sfraddr == c_ADDR_EM);

            // Software can only clear flags; a coincident edge re-sets the bit
            assign w_ef_kept = (sfrwe && w_hit_ef) ? (r_ef & sfrdatai) : r_ef;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pl <= RST_VAL;
                    r_ef <= '0;
                    r_em <= '0;
                end else begin
                    if (sfrwe && w_hit_pl) begin
                        r_pl <= sfrdatai;
                    end
                    if (sfrwe && w_hit_em) begin
                        r_em <= sfrdatai;
                    end
                    r_ef <= w_ef_kept | (w_edge[i*PW +: PW] & {PW{w_armed}});
                end
            end

            assign w_pl[i]   = r_pl;
            assign w_sel[i]  = w_hit_pl | w_hit_ef | w_hit_em;
            assign w_pend[i] = |(r_ef & r_em);
            assign w_rd[i]   = w_hit_pl ? (rmwinstr ? r_pl : w_s[i*PW +: PW]) :
                               w_hit_ef ? r_ef :
                               w_hit_em ? r_em : '0;
        end
    endgenerate

    // Address windows are disjoint, so OR-merging the per-port results is safe
    always_comb begin
        port_o    = '0;
        sfrdata_o = '0;
        sfrsel_o  = 1'b0;
        w_irq_any = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            port_o[p*PW +: PW] = (alt_en[p*PW +: PW] & alt_o[p*PW +: PW]) |
                                 (~alt_en[p*PW +: PW] & w_pl[p]);
            sfrdata_o = sfrdata_o | w_rd[p];
            sfrsel_o  = sfrsel_o | w_sel[p];
            w_irq_any = w_irq_any | w_pend[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_any;
        end
    end

    assign irq_o = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_port_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_port_bank
//  Description : Randomised self-checking bench for gpio_port_bank against a
//                cycle-level reference model built from the register rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_port_bank;

    localparam int NP = 4;
    localparam int PW = 8;
    localparam int SS = 2;
    localparam int BW = NP * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] port_i;
    logic [BW-1:0] port_o;
    logic [BW-1:0] alt_en;
    logic [BW-1:0] alt_o;
    logic          rmwinstr;
    logic [6:0]    sfraddr;
    logic [7:0]    sfrdatai;
    logic          sfrwe;
    logic [7:0]    sfrdata_o;
    logic          sfrsel_o;
    logic          irq_o;

    always #5 clk = ~clk;

    gpio_port_bank #(
        .NPORTS      (NP),
        .PW          (PW),
        .SYNC_STAGES (SS),
        .BASE_ADDR   (7'h00),
        .STRIDE      (7'h10),
        .RST_VAL     (8'hFF)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .port_i    (port_i),
        .port_o    (port_o),
        .alt_en    (alt_en),
        .alt_o     (alt_o),
        .rmwinstr  (rmwinstr),
        .sfraddr   (sfraddr),
        .sfrdatai  (sfrdatai),
        .sfrwe     (sfrwe),
        .sfrdata_o (sfrdata_o),
        .sfrsel_o  (sfrsel_o),
        .irq_o     (irq_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: pin history queue, newest first; the oldest entry is
    // what the CPU sees as the synchronised pin value.
    logic [BW-1:0] m_pl, m_ef, m_em, m_prev;
    logic          m_irq;
    logic [BW-1:0] m_hist[$];
    int            m_cnt;
    bit            m_valid = 1'b0;

    function automatic void model_reset();
        m_pl   = '1;
        m_ef   = '0;
        m_em   = '0;
        m_prev = '1;
        m_irq  = 1'b0;
        m_cnt  = 0;
        m_hist.delete();
        for (int k = 0; k < SS; k++) m_hist.push_back('1);
    endfunction

    function automatic void model_step();
        logic [BW-1:0] s_old, edges;
        if (rst) begin
            model_reset();
            m_valid = 1'b1;
            return;
        end
        s_old = m_hist[SS-1];
        edges = m_prev & ~s_old;
        m_irq = |(m_ef & m_em);
        if (sfrwe) begin
            for (int i = 0; i < NP; i++) begin
                if (int'(sfraddr) == i*16)     m_pl[i*8 +: 8] = sfrdatai;
                if (int'(sfraddr) == i*16 + 1) m_ef[i*8 +: 8] = m_ef[i*8 +: 8] & sfrdatai;
                if (int'(sfraddr) == i*16 + 2) m_em[i*8 +: 8] = sfrdatai;
            end
        end
        if (m_cnt >= SS + 1) m_ef = m_ef | edges;
        m_prev = s_old;
        m_hist.push_front(port_i);
        void'(m_hist.pop_back());
        if (m_cnt < 100) m_cnt++;
    endfunction

    function automatic void model_read(output logic [7:0] d, output logic s);
        logic [BW-1:0] sv;
        sv = m_hist[SS-1];
        d = 8'h00;
        s = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (int'(sfraddr) == i*16) begin
                s = 1'b1;
                d = rmwinstr ? m_pl[i*8 +: 8] : sv[i*8 +: 8];
            end else if (int'(sfraddr) == i*16 + 1) begin
                s = 1'b1;
                d = m_ef[i*8 +: 8];
            end else if (int'(sfraddr) == i*16 + 2) begin
                s = 1'b1;
                d = m_em[i*8 +: 8];
            end
        end
    endfunction

    // Called just after a negedge with inputs already driven.
    task automatic cycle();
        logic [7:0]    ed;
        logic          es;
        logic [BW-1:0] ep;
        #1;
        if (m_valid && !rst) begin
            model_read(ed, es);
            ep = (alt_en & alt_o) | (~alt_en & m_pl);
            check_eq("port_o", port_o, ep);
            check_eq("sfrdata", {24'h0, sfrdata_o}, {24'h0, ed});
            check_eq("sfrsel", {31'h0, sfrsel_o}, {31'h0, es});
            check_eq("irq", {31'h0, irq_o}, {31'h0, m_irq});
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic sfr_write(input logic [6:0] a, input logic [7:0] d);
        sfrwe    = 1'b1;
        sfraddr  = a;
        sfrdatai = d;
        cycle();
        sfrwe    = 1'b0;
    endtask

    task automatic read_expect(input logic [6:0] a, input logic rmw,
                               input logic [7:0] exp, input string tag);
        sfrwe    = 1'b0;
        sfraddr  = a;
        rmwinstr = rmw;
        #1;
        check_eq(tag, {24'h0, sfrdata_o}, {24'h0, exp});
        cycle();
    endtask

    initial begin
        rst      = 1'b1;
        port_i   = '0;
        alt_en   = '0;
        alt_o    = '0;
        rmwinstr = 1'b0;
        sfraddr  = 7'h7F;
        sfrdatai = 8'h00;
        sfrwe    = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        repeat (10) cycle();

        // Reset state with pins held low: no spurious flags
        check_eq("rst_port_o", port_o, 32'hFFFF_FFFF);
        check_eq("rst_irq", {31'h0, irq_o}, 32'h0);
        read_expect(7'h31, 1'b0, 8'h00, "rst_ef3");
        read_expect(7'h01, 1'b0, 8'h00, "rst_ef0");

        sfr_write(7'h10, 8'h5A);
        check_eq("pl1_pin", {24'h0, port_o[15:8]}, 32'h5A);
        read_expect(7'h10, 1'b1, 8'h5A, "pl1_rmw");

        port_i[23:16] = 8'h3C;
        read_expect(7'h20, 1'b0, 8'h00, "pin2_c0");
        read_expect(7'h20, 1'b0, 8'h00, "pin2_c1");
        read_expect(7'h20, 1'b0, 8'h3C, "pin2_c2");
        read_expect(7'h40, 1'b0, 8'h00, "unmapped_data");
        check_eq("unmapped_sel", {31'h0, sfrsel_o}, 32'h0);

        alt_en[7:4] = 4'hF;
        alt_o[7:4]  = 4'h3;
        #1;
        check_eq("alt_on", {24'h0, port_o[7:0]}, 32'h3F);
        cycle();
        alt_en = '0;
        #1;
        check_eq("alt_off", {24'h0, port_o[7:0]}, 32'hFF);
        cycle();

        // Falling edge on port 3 bit 0 with mask enabled
        sfr_write(7'h32, 8'h01);
        port_i[24] = 1'b1;
        repeat (4) cycle();
        port_i[24] = 1'b0;
        repeat (SS + 1) cycle();
        read_expect(7'h31, 1'b0, 8'h01, "ef3_set");
        check_eq("irq_set", {31'h0, irq_o}, 32'h1);
        sfr_write(7'h31, 8'hFE);
        cycle();
        check_eq("irq_clr", {31'h0, irq_o}, 32'h0);

        // Clear coinciding with a new edge on the same bit: edge wins
        port_i[24] = 1'b1;
        repeat (4) cycle();
        port_i[24] = 1'b0;
        repeat (SS) cycle();
        sfr_write(7'h31, 8'hFE);
        read_expect(7'h31, 1'b0, 8'h01, "ef3_race");
        sfr_write(7'h31, 8'h00);

        // Randomised traffic with occasional mid-run resets
        for (int n = 0; n < 1500; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            port_i   = port_i ^ ($urandom() & $urandom() & $urandom());
            if ($urandom_range(0, 15) == 0) alt_en = $urandom() & $urandom();
            alt_o    = $urandom();
            rmwinstr = $urandom_range(0, 1);
            sfrwe    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) sfraddr = 7'($urandom());
            else sfraddr = 7'($urandom_range(0, NP-1) * 16 + $urandom_range(0, 3));
            sfrdatai = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'($urandom() | $urandom());
            cycle();
        end
        rst   = 1'b0;
        sfrwe = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
